// File: rtl/simon_sequencer.sv
// simon_sequencer
//   Sequencer for a four-square "Simon" memory game. Each round appends one
//   pseudo-random direction to the sequence, plays the whole sequence back
//   through a square plotter (highlight, hold, restore, gap), then checks
//   the player's presses against it within an idle time limit.
//
// Ports
//   clock       in   single clock, rising edge
//   reset_n     in   synchronous active-low reset
//   start       in   1-cycle pulse, begins a game (accepted only in IDLE)
//   btn_valid   in   1-cycle pulse, debounced player press
//   btn_dir     in   [1:0] press direction (0 up, 1 down, 2 right, 3 left)
//   draw_req    out  plotter request, high in SHOW_REQ / HIDE_REQ only
//   draw_dir    out  [1:0] square to repaint
//   draw_color  out  [2:0] 3'b010 highlight, 3'b111 normal
//   draw_ack    in   plotter finished the current request
//   score       out  [4:0] rounds completed
//   busy        out  high whenever the FSM is not in IDLE
//   game_over   out  sticky loss flag, cleared by the next accepted start
//   win         out  sticky win flag, cleared by the next accepted start
//   dbg_state   out  [3:0] current FSM state, for observation only
//
// Plotter handshake: draw_req is raised with draw_dir/draw_color stable and
// stays high until draw_ack is sampled high on a rising edge; draw_req drops
// in the following cycle. draw_ack has no effect while draw_req is low.
module simon_sequencer #(
    parameter int MAX_LEN       = 16,
    parameter int ON_TICKS      = 25000000,
    parameter int OFF_TICKS     = 12500000,
    parameter int TIMEOUT_TICKS = 150000000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_dir,
    output logic       draw_req,
    output logic [1:0] draw_dir,
    output logic [2:0] draw_color,
    input  logic       draw_ack,
    output logic [4:0] score,
    output logic       busy,
    output logic       game_over,
    output logic       win,
    output logic [3:0] dbg_state
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [27:0] ON_LOAD      = 28'(ON_TICKS - 1);
    localparam logic [27:0] OFF_LOAD     = 28'(OFF_TICKS - 1);
    localparam logic [27:0] TIMEOUT_LOAD = 28'(TIMEOUT_TICKS - 1);
    localparam logic [4:0]  LEN_MAX      = 5'(MAX_LEN);

    localparam logic [2:0] COLOR_HI   = 3'b010;
    localparam logic [2:0] COLOR_NORM = 3'b111;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADD_STEP   = 4'd1,
        SHOW_REQ   = 4'd2,
        SHOW_HOLD  = 4'd3,
        HIDE_REQ   = 4'd4,
        HIDE_HOLD  = 4'd5,
        WAIT_INPUT = 4'd6,
        FAIL       = 4'd7,
        WIN        = 4'd8
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  lfsr;
    logic [1:0]  seq [MAX_LEN];
    logic [4:0]  len;
    logic [4:0]  idx;
    logic [27:0] timer;

    logic [1:0]  cur_step;
    logic        last_step;
    logic        timer_zero;
    logic        hit;

    assign cur_step   = seq[idx[IW-1:0]];
    assign last_step  = (idx == len - 5'd1);
    assign timer_zero = (timer == 28'd0);
    assign hit        = btn_valid && (btn_dir == cur_step);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = ADD_STEP;
            ADD_STEP:   state_next = SHOW_REQ;
            SHOW_REQ:   if (draw_ack) state_next = SHOW_HOLD;
            SHOW_HOLD:  if (timer_zero) state_next = HIDE_REQ;
            HIDE_REQ:   if (draw_ack) state_next = HIDE_HOLD;
            HIDE_HOLD: begin
                if (timer_zero) state_next = last_step ? WAIT_INPUT : SHOW_REQ;
            end
            WAIT_INPUT: begin
                // A press in the expiry cycle wins over the timeout.
                if (btn_valid) begin
                    if (!hit)           state_next = FAIL;
                    else if (last_step) state_next = (len == LEN_MAX) ? WIN : ADD_STEP;
                end else if (timer_zero) begin
                    state_next = FAIL;
                end
            end
            FAIL:       state_next = IDLE;
            WIN:        state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        draw_req   = 1'b0;
        draw_dir   = 2'd0;
        draw_color = COLOR_NORM;
        busy       = (state != IDLE);
        dbg_state  = state;
        if (state == SHOW_REQ) begin
            draw_req   = 1'b1;
            draw_dir   = cur_step;
            draw_color = COLOR_HI;
        end else if (state == HIDE_REQ) begin
            draw_req   = 1'b1;
            draw_dir   = cur_step;
            draw_color = COLOR_NORM;
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lfsr      <= 8'hA5;
            len       <= 5'd0;
            idx       <= 5'd0;
            timer     <= 28'd0;
            score     <= 5'd0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            // x^8+x^6+x^5+x^4+1 is maximal-length, so a non-zero seed never
            // reaches the all-zero lock-up state.
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                IDLE: begin
                    if (start) begin
                        len       <= 5'd0;
                        idx       <= 5'd0;
                        score     <= 5'd0;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                    end
                end
                ADD_STEP: begin
                    len <= len + 5'd1;
                    idx <= 5'd0;
                end
                SHOW_REQ: begin
                    if (draw_ack) timer <= ON_LOAD;
                end
                SHOW_HOLD: begin
                    if (!timer_zero) timer <= timer - 28'd1;
                end
                HIDE_REQ: begin
                    if (draw_ack) timer <= OFF_LOAD;
                end
                HIDE_HOLD: begin
                    if (!timer_zero) begin
                        timer <= timer - 28'd1;
                    end else if (last_step) begin
                        idx   <= 5'd0;
                        timer <= TIMEOUT_LOAD;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                WAIT_INPUT: begin
                    if (hit) begin
                        if (last_step) begin
                            score <= len;
                        end else begin
                            idx   <= idx + 5'd1;
                            timer <= TIMEOUT_LOAD;
                        end
                    end else if (!btn_valid && !timer_zero) begin
                        timer <= timer - 28'd1;
                    end
                end
                FAIL:    game_over <= 1'b1;
                WIN:     win       <= 1'b1;
                default: ;
            endcase
        end
    end

    // Sequence storage has no reset: every entry is written in ADD_STEP
    // before playback or input checking can read it.
    always_ff @(posedge clock) begin
        if (state == ADD_STEP) begin
            seq[len[IW-1:0]] <= lfsr[1:0];
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// tb_simon_sequencer
//   Directed game scenarios with randomized press timing, wrong-press
//   choice and noise on ignored inputs. Expected draws come from a sequence
//   model fed by a free-running LFSR model (seed 8'hA5 on reset, one step
//   per clock); the plotter answers each request 2 cycles after it rises.
module tb_simon_sequencer;

    localparam int MAX_LEN = 4;
    localparam int ON_T    = 4;
    localparam int OFF_T   = 2;
    localparam int TO_T    = 20;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_dir = 2'd0;
    logic       draw_ack = 1'b0;
    logic       draw_req;
    logic [1:0] draw_dir;
    logic [2:0] draw_color;
    logic [4:0] score;
    logic       busy;
    logic       game_over;
    logic       win;
    logic [3:0] dbg_state;

    simon_sequencer #(
        .MAX_LEN(MAX_LEN),
        .ON_TICKS(ON_T),
        .OFF_TICKS(OFF_T),
        .TIMEOUT_TICKS(TO_T)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .btn_valid(btn_valid),
        .btn_dir(btn_dir),
        .draw_req(draw_req),
        .draw_dir(draw_dir),
        .draw_color(draw_color),
        .draw_ack(draw_ack),
        .score(score),
        .busy(busy),
        .game_over(game_over),
        .win(win),
        .dbg_state(dbg_state)
    );

    // ---------------------------------------------------------------- clock / reset
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- reference model
    // lfsr_cur is the generator value during the current cycle (as seen at
    // the falling edge); a step is appended from the value during ADD_STEP.
    logic [7:0] lfsr_cur;
    initial begin
        forever begin
            @(posedge clock);
            if (!reset_n) lfsr_cur = 8'hA5;
            else          lfsr_cur = {lfsr_cur[6:0], ^(lfsr_cur & 8'b1011_1000)};
        end
    end

    logic [1:0] seq_m[$];
    logic [4:0] exp_q[$];   // {dir, color} of each expected plotter request

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------- scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(draw_req),   32'd0);
        check({tag, "_dir"},   32'(draw_dir),   32'd0);
        check({tag, "_color"}, 32'(draw_color), 32'd7);
        check({tag, "_score"}, 32'(score),      32'd0);
        check({tag, "_over"},  32'(game_over),  32'd0);
        check({tag, "_win"},   32'(win),        32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    // Leaves the bench on the falling edge of the ADD_STEP cycle.
    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits 'gap' cycles for a request, checks it against the queue head,
    // holds draw_ack off for ack_delay cycles (with noise on the ignored
    // inputs), acks, and checks the request drops one cycle later.
    task automatic handshake(input int gap, input int ack_delay);
        logic [4:0] e;
        int n;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        while (!draw_req && n < gap + 60) begin
            tick();
            n++;
        end
        check("req_gap", 32'(n), 32'(gap));
        if (!draw_req) return;
        check("draw_item", 32'({draw_dir, draw_color}), 32'(e));
        for (int i = 0; i < ack_delay; i++) begin
            btn_valid = 1'($urandom_range(0, 1));
            btn_dir   = 2'($urandom_range(0, 3));
            start     = 1'($urandom_range(0, 1));
            tick();
            if (!draw_req || {draw_dir, draw_color} !== e)
                check("req_hold", 32'({draw_req, draw_dir, draw_color}), 32'({1'b1, e}));
        end
        btn_valid = 1'b0;
        start     = 1'b0;
        draw_ack  = 1'b1;
        tick();
        draw_ack  = 1'b0;
        check("req_drop", 32'(draw_req), 32'd0);
    endtask

    // Entered on the falling edge of ADD_STEP; plays back the grown sequence
    // and leaves the bench on the falling edge of the first WAIT_INPUT cycle.
    task automatic play_round(input bit long_ack);
        seq_m.push_back(lfsr_cur[1:0]);
        exp_q.delete();
        foreach (seq_m[i]) begin
            exp_q.push_back({seq_m[i], 3'b010});
            exp_q.push_back({seq_m[i], 3'b111});
        end
        for (int i = 0; i < seq_m.size(); i++) begin
            handshake((i == 0) ? 1 : OFF_T, (i == 0 && long_ack) ? 50 : 2);
            handshake(ON_T, 2);
        end
        repeat (OFF_T) tick();
        check("wait_busy", 32'(busy), 32'd1);
    endtask

    // Press 'delay' cycles after the timer was (re)loaded; delay TO_T-1 lands
    // in the expiry cycle. draw_ack noise while draw_req is low is ignored.
    task automatic press(input logic [1:0] dir, input int delay);
        for (int d = 0; d < delay; d++) begin
            draw_ack = 1'($urandom_range(0, 1));
            tick();
        end
        draw_ack  = 1'b0;
        btn_valid = 1'b1;
        btn_dir   = dir;
        tick();
        btn_valid = 1'b0;
    endtask

    task automatic play_correct_round(input int r, input bit long_ack, input int slow_press);
        int d;
        play_round(long_ack);
        for (int i = 0; i < r; i++) begin
            d = (i == slow_press) ? TO_T - 1 : $urandom_range(0, 4);
            press(seq_m[i], d);
        end
        check("score_step", 32'(score), 32'(r));
        check("no_over", 32'(game_over), 32'd0);
        if (r == MAX_LEN) begin
            tick();
            check("win_flag", 32'(win), 32'd1);
            check("win_idle", 32'(busy), 32'd0);
            check("win_score", 32'(score), 32'(MAX_LEN));
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit saw_req;
        logic [1:0] wrong;

        repeat (3) tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Full game to a win; round 2 also holds the first ack off for 50
        // cycles and makes its last press in the timeout cycle, round 3 its
        // first press.
        start_game();
        play_correct_round(1, 1'b0, -1);
        play_correct_round(2, 1'b1, 1);
        play_correct_round(3, 1'b0, 0);
        play_correct_round(4, 1'b0, -1);
        repeat (3) tick();
        check("win_hold", 32'(win), 32'd1);

        // Wrong second press in round 2.
        seq_m.delete();
        start_game();
        check("start_clr_score", 32'(score), 32'd0);
        check("start_clr_win", 32'(win), 32'd0);
        play_correct_round(1, 1'b0, -1);
        play_round(1'b0);
        press(seq_m[0], $urandom_range(0, 5));
        wrong = seq_m[1] ^ 2'($urandom_range(1, 3));
        press(wrong, $urandom_range(0, 5));
        check("fail_state_busy", 32'(busy), 32'd1);
        tick();
        check("wrong_over", 32'(game_over), 32'd1);
        check("wrong_score", 32'(score), 32'd1);
        check("wrong_idle", 32'(busy), 32'd0);
        check("wrong_win", 32'(win), 32'd0);
        saw_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (draw_req) saw_req = 1'b1;
        end
        check("no_req_after_fail", 32'(saw_req), 32'd0);
        check("over_hold", 32'(game_over), 32'd1);

        // Reset in the middle of the HIDE_REQ handshake.
        seq_m.delete();
        start_game();
        check("start_clr_over", 32'(game_over), 32'd0);
        seq_m.push_back(lfsr_cur[1:0]);
        exp_q.delete();
        exp_q.push_back({seq_m[0], 3'b010});
        handshake(1, 2);
        repeat (ON_T) tick();
        check("hide_req_up", 32'({draw_req, draw_color}), 32'({1'b1, 3'b111}));
        reset_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        tick();

        // New game after reset plays a single step, then times out.
        seq_m.delete();
        start_game();
        play_round(1'b0);
        check("one_step_only", 32'(seq_m.size() + exp_q.size()), 32'd1);
        saw_req = 1'b0;
        for (int i = 0; i < TO_T; i++) begin
            tick();
            if (!busy || game_over || draw_req) saw_req = 1'b1;
        end
        check("timeout_not_early", 32'(saw_req), 32'd0);
        tick();
        check("timeout_over", 32'(game_over), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_score", 32'(score), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
